// File: rtl/bus_err_collector.sv
// Bus error collector.
// Pops error entries from an upstream error FIFO, presents each one as a
// record on a valid/ready sink port, keeps saturating per-code and total
// error counters, flags upstream overflow since the previous capture and
// raises a registered threshold interrupt.
// Optional timestamping of records: define BUS_ERR_COLLECTOR_TIMESTAMP_EN.
//
// Handshake: a record transfers on any cycle with rec_valid_o=1 and
// rec_ready_i=1. Once rec_valid_o is high the rec_* fields stay stable until
// that transfer. A new entry is popped (src_pop_o=1) in the same cycle the
// previous record transfers, so back-to-back records stream at one per cycle.
module bus_err_collector #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned MetaDataWidth = 1,
  parameter int unsigned ErrBits       = 3,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned TsWidth       = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clear_i,
  // upstream error FIFO
  input  logic                                src_valid_i,
  output logic                                src_pop_o,
  input  logic [ErrBits-1:0]                  src_code_i,
  input  logic [AddrWidth-1:0]                src_addr_i,
  input  logic [MetaDataWidth-1:0]            src_meta_i,
  input  logic                                src_overflow_i,
  // record sink
  output logic                                rec_valid_o,
  input  logic                                rec_ready_i,
  output logic [ErrBits-1:0]                  rec_code_o,
  output logic [AddrWidth-1:0]                rec_addr_o,
  output logic [MetaDataWidth-1:0]            rec_meta_o,
  output logic [TsWidth-1:0]                  rec_ts_o,
  output logic                                rec_lost_o,
  // statistics
  output logic [2**ErrBits-1:0][CntWidth-1:0] err_cnt_o,
  output logic [CntWidth-1:0]                 total_cnt_o,
  input  logic [CntWidth-1:0]                 thresh_i,
  output logic                                irq_o,
  // debug: 1 while a record is held (SEND)
  output logic                                state_o
);

  localparam int unsigned NumCodes = 2**ErrBits;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                                 state_q;
  logic                                   capture;
  logic                                   count_en;
  logic                                   lost_q;
  logic [NumCodes-1:0][CntWidth-1:0]      cnt_q;
  logic [NumCodes-1:0][CntWidth-1:0]      cnt_next;
  logic [CntWidth-1:0]                    total_q;
  logic [CntWidth-1:0]                    total_next;

  // An entry is taken when the output slot is free or is being emptied this
  // cycle. Gated with rst_ni so nothing is popped while reset is held.
  assign capture   = rst_ni & src_valid_i & ((state_q == IDLE) | rec_ready_i);
  assign src_pop_o = capture;

  // Code 0 means "no error" and is never counted.
  assign count_en  = capture & (src_code_i != '0);

  assign state_o     = (state_q == SEND);
  assign err_cnt_o   = cnt_q;
  assign total_cnt_o = total_q;

  // Record FSM: state, rec_valid_o and the captured record fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rec_valid_o <= 1'b0;
      rec_code_o  <= '0;
      rec_addr_o  <= '0;
      rec_meta_o  <= '0;
      rec_lost_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            state_q     <= SEND;
            rec_valid_o <= 1'b1;
          end
        end
        SEND: begin
          // Held record drains; stay in SEND if a new entry replaces it.
          if (rec_ready_i && !src_valid_i) begin
            state_q     <= IDLE;
            rec_valid_o <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rec_valid_o <= 1'b0;
        end
      endcase
      if (capture) begin
        rec_code_o <= src_code_i;
        rec_addr_o <= src_addr_i;
        rec_meta_o <= src_meta_i;
        rec_lost_o <= lost_q;
      end
    end
  end

  // Lost flag: set by upstream overflow, consumed by a capture; clear wins,
  // and an overflow in the capture cycle keeps it set for the next record.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lost_q <= 1'b0;
    end else if (clear_i) begin
      lost_q <= 1'b0;
    end else if (src_overflow_i) begin
      lost_q <= 1'b1;
    end else if (capture) begin
      lost_q <= 1'b0;
    end
  end

  // Next counter values: clear first, then a saturating increment.
  always_comb begin
    cnt_next   = cnt_q;
    total_next = total_q;
    for (int i = 0; i < NumCodes; i++) begin
      if (clear_i || i == 0) begin
        cnt_next[i] = '0;
      end else if (count_en && (src_code_i == ErrBits'(i)) && (cnt_q[i] != '1)) begin
        cnt_next[i] = cnt_q[i] + CntWidth'(1);
      end
    end
    if (clear_i) begin
      total_next = '0;
    end else if (count_en && (total_q != '1)) begin
      total_next = total_q + CntWidth'(1);
    end
  end

  // Counter registers and the threshold interrupt, which is derived from the
  // next total so irq_o moves in the same cycle as total_cnt_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      total_q <= '0;
      irq_o   <= 1'b0;
    end else begin
      cnt_q   <= cnt_next;
      total_q <= total_next;
      irq_o   <= (thresh_i != '0) && (total_next >= thresh_i);
    end
  end

`ifdef BUS_ERR_COLLECTOR_TIMESTAMP_EN
  logic [TsWidth-1:0] ts_q;
  logic [TsWidth-1:0] rec_ts_q;

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TsWidth'(1);
    end
  end

  // Timestamp of the capture cycle travels with the record.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rec_ts_q <= '0;
    end else if (capture) begin
      rec_ts_q <= ts_q;
    end
  end

  assign rec_ts_o = rec_ts_q;
`else
  assign rec_ts_o = '0;
`endif

endmodule
